// File: rtl/gpio_input_module.sv
// rtl/gpio_input_module.sv - button/switch synchroniser, debouncer and start/abort launch FSM
module gpio_input_module #(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 5,
  parameter int NUM_SW    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_start_raw,
  input  logic              btn_abort_raw,
  input  logic [NUM_SW-1:0] sw_raw,
  input  logic              start_ack,
  input  logic              core_done,
  output logic              start_req,
  output logic [NUM_SW-1:0] core_sel,
  output logic              abort_pulse,
  output logic              busy,
  output logic              done,
  output logic [NUM_SW-1:0] sw_db
);

  localparam int NIN       = NUM_SW + 2;
  localparam int START_IDX = NUM_SW;
  localparam int ABORT_IDX = NUM_SW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  logic [NIN-1:0]   raw_in;
  logic [NIN-1:0]   sync1;
  logic [NIN-1:0]   sync2;
  logic [NIN-1:0]   db;
  logic [NIN-1:0]   db_prev;
  logic [CNT_W-1:0] cnt [NIN];

  logic start_rise;
  logic abort_rise;
  logic launch;

  state_t            state;
  state_t            state_d;
  logic              start_req_d;
  logic              done_d;
  logic              abort_d;
  logic [NUM_SW-1:0] core_sel_d;

  assign raw_in = {btn_abort_raw, btn_start_raw, sw_raw};

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  // A level is accepted only after DB_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NIN; i++) cnt[i] <= '0;
      db      <= '0;
      db_prev <= '0;
    end else begin
      db_prev <= db;
      for (int i = 0; i < NIN; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          cnt[i] <= '0;
          db[i]  <= ~db[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign sw_db      = db[NUM_SW-1:0];
  assign start_rise = db[START_IDX] & ~db_prev[START_IDX];
  assign abort_rise = db[ABORT_IDX] & ~db_prev[ABORT_IDX];
  assign launch     = start_rise & (|sw_db);

  always_comb begin
    state_d     = state;
    start_req_d = start_req;
    core_sel_d  = core_sel;
    done_d      = done;
    abort_d     = abort_rise;
    if (abort_rise) begin
      state_d     = IDLE;
      start_req_d = 1'b0;
      core_sel_d  = '0;
      done_d      = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            core_sel_d  = sw_db;
            start_req_d = 1'b1;
            state_d     = REQ;
          end
        end
        REQ: begin
          if (start_ack) begin
            start_req_d = 1'b0;
            state_d     = RUN;
          end
        end
        RUN: begin
          if (core_done) begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
        DONE: begin
          if (launch) begin
            done_d      = 1'b0;
            core_sel_d  = sw_db;
            start_req_d = 1'b1;
            state_d     = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      start_req   <= 1'b0;
      core_sel    <= '0;
      done        <= 1'b0;
      abort_pulse <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      start_req   <= start_req_d;
      core_sel    <= core_sel_d;
      done        <= done_d;
      abort_pulse <= abort_d;
      busy        <= (state_d == REQ) || (state_d == RUN);
    end
  end

endmodule

// File: tb/tb_gpio_input_module.sv
// tb/tb_gpio_input_module.sv - vector table, corner sequences and random run against a reference model
module tb_gpio_input_module;

  localparam int DB  = 4;
  localparam int CW  = 3;
  localparam int NSW = 4;

  localparam int S_IDLE = 0;
  localparam int S_REQ  = 1;
  localparam int S_RUN  = 2;
  localparam int S_DONE = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           btn_start_raw;
  logic           btn_abort_raw;
  logic [NSW-1:0] sw_raw;
  logic           start_ack;
  logic           core_done;
  logic           start_req;
  logic [NSW-1:0] core_sel;
  logic           abort_pulse;
  logic           busy;
  logic           done;
  logic [NSW-1:0] sw_db;

  always #5 clk = ~clk;

  gpio_input_module #(
    .DB_CYCLES(DB),
    .CNT_W    (CW),
    .NUM_SW   (NSW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_start_raw(btn_start_raw),
    .btn_abort_raw(btn_abort_raw),
    .sw_raw       (sw_raw),
    .start_ack    (start_ack),
    .core_done    (core_done),
    .start_req    (start_req),
    .core_sel     (core_sel),
    .abort_pulse  (abort_pulse),
    .busy         (busy),
    .done         (done),
    .sw_db        (sw_db)
  );

  int checks = 0;
  int errors = 0;

  // Packed output view: {start_req, core_sel, abort_pulse, busy, done, sw_db}
  wire [11:0] dut_out = {start_req, core_sel, abort_pulse, busy, done, sw_db};

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: {req,sel,abort,busy,done,sw_db} got %b_%b_%b_%b_%b_%b want %b_%b_%b_%b_%b_%b",
               name, act[11], act[10:7], act[6], act[5], act[4], act[3:0],
               exp[11], exp[10:7], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  // Reference model: a new level is accepted once the last DB samples seen
  // past the 2-flop synchroniser all disagree with the accepted level.
  logic [5:0] m_h [DB+1];
  logic [5:0] m_db;
  logic [5:0] m_prev;
  int         m_state;
  logic       m_req;
  logic [3:0] m_sel;
  logic       m_abort;
  logic       m_busy;
  logic       m_done;

  function automatic logic [11:0] model_out();
    return {m_req, m_sel, m_abort, m_busy, m_done, m_db[3:0]};
  endfunction

  task automatic model_step();
    logic [5:0] nxt;
    logic       s_rise;
    logic       a_rise;
    logic       launch;
    logic [3:0] swd;
    bit         all_diff;
    if (!rst) begin
      for (int j = 0; j <= DB; j++) m_h[j] = '0;
      m_db = '0; m_prev = '0; m_state = S_IDLE;
      m_req = 0; m_sel = '0; m_abort = 0; m_busy = 0; m_done = 0;
      return;
    end
    swd    = m_db[3:0];
    s_rise = m_db[4] && !m_prev[4];
    a_rise = m_db[5] && !m_prev[5];
    launch = s_rise && (swd != 4'd0);
    m_abort = a_rise;
    if (a_rise) begin
      m_state = S_IDLE; m_req = 0; m_sel = '0; m_done = 0;
    end else begin
      case (m_state)
        S_IDLE: if (launch) begin m_sel = swd; m_req = 1; m_state = S_REQ; end
        S_REQ:  if (start_ack) begin m_req = 0; m_state = S_RUN; end
        S_RUN:  if (core_done) begin m_done = 1; m_state = S_DONE; end
        default: if (launch) begin m_done = 0; m_sel = swd; m_req = 1; m_state = S_REQ; end
      endcase
    end
    m_busy = (m_state == S_REQ) || (m_state == S_RUN);
    nxt = m_db;
    for (int i = 0; i < 6; i++) begin
      all_diff = 1;
      for (int j = 1; j <= DB; j++) if (m_h[j][i] == m_db[i]) all_diff = 0;
      if (all_diff) nxt[i] = ~m_db[i];
    end
    m_prev = m_db;
    m_db   = nxt;
    for (int j = DB; j >= 1; j--) m_h[j] = m_h[j-1];
    m_h[0] = {btn_abort_raw, btn_start_raw, sw_raw};
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check({"model ", tag}, dut_out, model_out());
  endtask

  task automatic drive(input logic r, input logic st, input logic ab,
                       input logic [3:0] sw, input logic ack, input logic cd);
    rst = r; btn_start_raw = st; btn_abort_raw = ab;
    sw_raw = sw; start_ack = ack; core_done = cd;
  endtask

  typedef struct {
    logic       r;
    logic       st;
    logic       ab;
    logic [3:0] sw;
    logic       ack;
    logic       cd;
    int         n;
    logic [11:0] exp;
  } vec_t;

  function automatic vec_t mk(logic r, logic st, logic ab, logic [3:0] sw, logic ack, logic cd,
                              int n, logic req, logic [3:0] sel, logic ap, logic bz,
                              logic dn, logic [3:0] swdb);
    vec_t v;
    v.r = r; v.st = st; v.ab = ab; v.sw = sw; v.ack = ack; v.cd = cd; v.n = n;
    v.exp = {req, sel, ap, bz, dn, swdb};
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    int   n;
    logic r, st, ab, ack, cd;
    logic [3:0] sw;

    //            r st ab sw      ack cd n   req sel     ap bz dn swdb
    tbl.push_back(mk(1, 0, 0, 4'b0101, 0, 0, 5,  0, 4'b0000, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(1, 0, 0, 4'b0101, 0, 0, 1,  0, 4'b0000, 0, 0, 0, 4'b0101));
    tbl.push_back(mk(1, 0, 0, 4'b0011, 0, 0, 6,  0, 4'b0000, 0, 0, 0, 4'b0011));
    tbl.push_back(mk(1, 1, 0, 4'b0011, 0, 0, 6,  0, 4'b0000, 0, 0, 0, 4'b0011));
    tbl.push_back(mk(1, 1, 0, 4'b0011, 0, 0, 1,  1, 4'b0011, 0, 1, 0, 4'b0011));
    tbl.push_back(mk(1, 1, 0, 4'b0011, 0, 0, 3,  1, 4'b0011, 0, 1, 0, 4'b0011));
    tbl.push_back(mk(1, 0, 0, 4'b0011, 0, 0, 1,  1, 4'b0011, 0, 1, 0, 4'b0011));
    tbl.push_back(mk(1, 0, 0, 4'b0011, 1, 0, 1,  0, 4'b0011, 0, 1, 0, 4'b0011));
    tbl.push_back(mk(1, 0, 0, 4'b0011, 0, 0, 5,  0, 4'b0011, 0, 1, 0, 4'b0011));
    tbl.push_back(mk(1, 0, 0, 4'b0011, 0, 1, 1,  0, 4'b0011, 0, 0, 1, 4'b0011));
    tbl.push_back(mk(1, 0, 0, 4'b1000, 0, 0, 6,  0, 4'b0011, 0, 0, 1, 4'b1000));
    tbl.push_back(mk(1, 1, 0, 4'b1000, 0, 0, 6,  0, 4'b0011, 0, 0, 1, 4'b1000));
    tbl.push_back(mk(1, 1, 0, 4'b1000, 1, 0, 1,  1, 4'b1000, 0, 1, 0, 4'b1000));
    tbl.push_back(mk(1, 0, 0, 4'b1000, 1, 0, 1,  0, 4'b1000, 0, 1, 0, 4'b1000));
    tbl.push_back(mk(1, 0, 0, 4'b1000, 0, 0, 8,  0, 4'b1000, 0, 1, 0, 4'b1000));
    tbl.push_back(mk(1, 1, 0, 4'b0110, 0, 0, 8,  0, 4'b1000, 0, 1, 0, 4'b0110));
    tbl.push_back(mk(1, 0, 0, 4'b0110, 0, 1, 1,  0, 4'b1000, 0, 0, 1, 4'b0110));
    tbl.push_back(mk(1, 0, 0, 4'b0110, 0, 0, 8,  0, 4'b1000, 0, 0, 1, 4'b0110));
    tbl.push_back(mk(1, 1, 0, 4'b0110, 0, 0, 7,  1, 4'b0110, 0, 1, 0, 4'b0110));
    tbl.push_back(mk(1, 0, 1, 4'b0110, 0, 0, 6,  1, 4'b0110, 0, 1, 0, 4'b0110));
    tbl.push_back(mk(1, 0, 1, 4'b0110, 0, 0, 1,  0, 4'b0000, 1, 0, 0, 4'b0110));
    tbl.push_back(mk(1, 0, 1, 4'b0110, 0, 0, 1,  0, 4'b0000, 0, 0, 0, 4'b0110));
    tbl.push_back(mk(1, 0, 0, 4'b0110, 0, 0, 8,  0, 4'b0000, 0, 0, 0, 4'b0110));
    tbl.push_back(mk(1, 0, 0, 4'b0000, 0, 0, 6,  0, 4'b0000, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 0, 0, 8,  0, 4'b0000, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(1, 0, 0, 4'b0000, 0, 0, 8,  0, 4'b0000, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(1, 1, 1, 4'b0101, 0, 0, 6,  0, 4'b0000, 0, 0, 0, 4'b0101));
    tbl.push_back(mk(1, 1, 1, 4'b0101, 0, 0, 1,  0, 4'b0000, 1, 0, 0, 4'b0101));
    tbl.push_back(mk(1, 1, 1, 4'b0101, 0, 0, 1,  0, 4'b0000, 0, 0, 0, 4'b0101));
    tbl.push_back(mk(1, 0, 0, 4'b0101, 0, 0, 8,  0, 4'b0000, 0, 0, 0, 4'b0101));
    tbl.push_back(mk(1, 1, 0, 4'b0101, 0, 0, 3,  0, 4'b0000, 0, 0, 0, 4'b0101));
    tbl.push_back(mk(1, 0, 0, 4'b0101, 0, 0, 8,  0, 4'b0000, 0, 0, 0, 4'b0101));
    tbl.push_back(mk(1, 1, 0, 4'b1111, 0, 0, 7,  1, 4'b1111, 0, 1, 0, 4'b1111));
    tbl.push_back(mk(1, 0, 0, 4'b1111, 1, 0, 1,  0, 4'b1111, 0, 1, 0, 4'b1111));
    tbl.push_back(mk(0, 0, 0, 4'b1111, 0, 0, 1,  0, 4'b0000, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(1, 0, 0, 4'b1111, 1, 1, 10, 0, 4'b0000, 0, 0, 0, 4'b1111));
    tbl.push_back(mk(1, 0, 0, 4'b1111, 0, 0, 1,  0, 4'b0000, 0, 0, 0, 4'b1111));

    // Reset held for three edges, then a quiet idle period.
    drive(0, 0, 0, 4'b0000, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick("reset");
      check("reset_hold", dut_out, 12'h000);
    end
    drive(1, 0, 0, 4'b0000, 0, 0);
    for (int i = 0; i < 50; i++) begin
      tick("idle");
      check("idle_quiet", dut_out, 12'h000);
    end

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].r, tbl[k].st, tbl[k].ab, tbl[k].sw, tbl[k].ack, tbl[k].cd);
      for (int c = 0; c < tbl[k].n; c++) tick($sformatf("vec%0d", k));
      check($sformatf("vec%0d", k), dut_out, tbl[k].exp);
    end

    // Randomised segments of held inputs, mixing accepted presses and glitches.
    sw = 4'b0000;
    for (int seg = 0; seg < 400; seg++) begin
      r   = ($urandom_range(0, 39) != 0);
      st  = ($urandom_range(0, 2) == 0);
      ab  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) sw = 4'($urandom_range(0, 15));
      ack = ($urandom_range(0, 2) == 0);
      cd  = ($urandom_range(0, 3) == 0);
      n   = r ? $urandom_range(1, 10) : 1;
      drive(r, st, ab, sw, ack, cd);
      for (int c = 0; c < n; c++) tick("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_input_module.md
Name: gpio_input_module

Overview:
- Input-side counterpart to the board LED driver.
- Synchronises and debounces the raw push buttons (start, abort) and core-select switches.
- Detects button presses and runs a launch FSM that issues a req/ack start handshake to the core controller with a latched core-select mask, then tracks completion.
- Exposes busy/done status, which the LED driver can display.

Parameters:
DB_CYCLES, 16, consecutive stable cycles required before a debounced input changes (>=2)
CNT_W, 5, debounce counter width; must satisfy 2^CNT_W > DB_CYCLES
NUM_SW, 4, number of core-select switches (one per core)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-low reset
btn_start_raw  input  1  asynchronous start push button, high = pressed
btn_abort_raw  input  1  asynchronous abort push button, high = pressed
sw_raw  input  NUM_SW  asynchronous core-select switches
start_ack  input  1  core controller accepts start request
core_done  input  1  level, high when selected cores have finished
start_req  output  1  start request to core controller
core_sel  output  NUM_SW  core mask latched at launch, held stable while busy
abort_pulse  output  1  one-cycle abort strobe to core controller
busy  output  1  high in REQ and RUN
done  output  1  sticky completion flag
sw_db  output  NUM_SW  debounced switch levels

Behaviour:
- Reset (rst low at a clk edge) clears every flop: all outputs 0, sync and debounce state 0, counters 0, FSM to IDLE. This applies mid-operation too; start_req drops on that edge.
- Synchroniser: each of the NUM_SW+2 raw inputs passes through 2 flops.
- Debounce, per input, one counter plus one db level:
  - If synced != db: counter +1.
  - When counter == DB_CYCLES-1 and mismatch persists: db toggles and counter clears.
  - If synced == db: counter clears.
  - Effect: db changes on edge DB_CYCLES+2 after the first edge that samples the new raw value. Any glitch shorter than DB_CYCLES cycles is rejected.
- Edge detect: start_rise and abort_rise are 1-cycle pulses (db & ~db_prev). Releases produce nothing.
- FSM states: IDLE, REQ, RUN, DONE. busy is registered and high exactly in REQ and RUN.
  - IDLE: on start_rise with sw_db != 0, latch core_sel <= sw_db, set start_req <= 1, go to REQ. start_rise with sw_db == 0 is ignored and the FSM stays in IDLE.
  - REQ: hold start_req high. When start_ack is sampled high, clear start_req and go to RUN. start_ack is sampled the cycle after start_req rises at the earliest.
  - RUN: when core_done is sampled high, set done <= 1 and go to DONE.
  - DONE: done held high, core_sel retained. On start_rise with sw_db != 0: clear done, latch the new core_sel, assert start_req, go to REQ. Otherwise stay.
- Ignored inputs: start_ack outside REQ; core_done outside RUN; start_rise in REQ or RUN (no retrigger while busy).
- Abort (any state): abort_rise forces next cycle abort_pulse = 1 (exactly one cycle), start_req = 0, done = 0, core_sel = 0, FSM to IDLE.
- Simultaneous events:
  - abort_rise with start_rise, start_ack or core_done: abort wins.
  - start_ack arriving on the same cycle start_req is first driven: ignored, because the FSM is not yet in REQ.
- sw_db tracks the switches continuously. Switch changes after launch do not alter core_sel.

Test Plan (DB_CYCLES=4):
- Reset then idle: hold rst low 3 cycles, release, no input activity -> all outputs 0, FSM IDLE for 50 cycles.
- Debounce: sw_raw=4'b0101 stable -> sw_db=4'b0101 exactly 6 edges after the first sampling edge. A 3-cycle 1-glitch on btn_start_raw -> no start_req.
- Full launch: sw=4'b0011, press start 10 cycles -> start_req=1, busy=1, core_sel=4'b0011. Ack after 5 cycles -> start_req=0 next edge. core_done pulse -> done=1, busy=0. Second press with sw=4'b1000 -> done=0, core_sel=4'b1000, start_req=1.
- Zero mask / retrigger: press start with sw=0 -> stays IDLE. Press start while in RUN -> ignored, core_sel unchanged.
- Abort: in REQ press abort -> one-cycle abort_pulse, start_req=0, core_sel=0, busy=0. Start and abort debounced on the same cycle -> abort wins, FSM stays IDLE.
- Reset mid-run: in RUN with core_sel=4'b1111, pull rst low one edge -> all outputs 0. Late start_ack and core_done are then ignored.
